// File: rtl/fir_tap_loader.sv
// Tap-load sequencer for the slow FIR: streams host coefficients into the tap-write
// port, optionally flushes the delay line (FIR_TAP_LOADER_FLUSH_EN), then gates sample strobes.
module fir_tap_loader #(
    parameter int NTAPS = 16,
    parameter int TAP_W = 16,
    parameter int CNT_W = $clog2(NTAPS + 1)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_tap_valid,
    output logic             o_tap_ready,
    input  logic [TAP_W-1:0] i_tap_data,
    input  logic             i_sample_stb,
    output logic             o_tap_wr,
    output logic [TAP_W-1:0] o_tap,
    output logic             o_ce,
    output logic             o_zero_sample,
    output logic             o_loaded,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_tap_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               start_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               tap_wr_q, tap_wr_d;
    logic [TAP_W-1:0]   tap_q, tap_d;
    logic               ce_q, ce_d;
    logic               zero_q, zero_d;
    logic               loaded_q, loaded_d;
    logic               start_edge_s;
    logic               hs_s;
    logic               last_tap_s;

    assign start_edge_s = start_q & ~i_start;
    assign hs_s         = i_tap_valid & (state_q == S_LOAD);
    assign last_tap_s   = hs_s & (count_q == CNT_W'(NTAPS - 1));

`ifdef FIR_TAP_LOADER_FLUSH_EN
    logic [CNT_W-1:0]   flush_q, flush_d;
    logic               last_flush_s;

    assign last_flush_s = i_sample_stb & (flush_q == CNT_W'(NTAPS - 1));

    // Flush strobe counter, restarted by the last tap handshake.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            flush_q <= {CNT_W{1'b0}};
        end else begin
            flush_q <= flush_d;
        end
    end

    // Flush counter next value.
    always_comb begin
        flush_d = flush_q;
        if (last_tap_s) begin
            flush_d = {CNT_W{1'b0}};
        end else if ((state_q == S_FLUSH) && i_sample_stb) begin
            flush_d = flush_q + CNT_W'(1);
        end else begin
            flush_d = flush_q;
        end
    end
`endif

    // State register and start-request history (idle high, so reset value 1).
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            start_q <= 1'b1;
        end else begin
            state_q <= state_d;
            start_q <= i_start;
        end
    end

    // Next-state logic; start edges are deliberately ignored while loading.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_edge_s) state_d = S_LOAD;
                else              state_d = S_IDLE;
            end
            S_LOAD: begin
`ifdef FIR_TAP_LOADER_FLUSH_EN
                if (last_tap_s) state_d = S_FLUSH;
                else            state_d = S_LOAD;
`else
                if (last_tap_s) state_d = S_RUN;
                else            state_d = S_LOAD;
`endif
            end
`ifdef FIR_TAP_LOADER_FLUSH_EN
            S_FLUSH: begin
                if (start_edge_s)      state_d = S_LOAD;
                else if (last_flush_s) state_d = S_RUN;
                else                   state_d = S_FLUSH;
            end
`endif
            S_RUN: begin
                if (start_edge_s) state_d = S_LOAD;
                else              state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output and counter next values; ready/busy come from state alone.
    always_comb begin
        count_d  = count_q;
        if (start_edge_s && (state_q != S_LOAD)) begin
            count_d = {CNT_W{1'b0}};
        end else if (hs_s) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q;
        end
        tap_wr_d = hs_s;
        if (hs_s) begin
            tap_d = i_tap_data;
        end else begin
            tap_d = tap_q;
        end
        ce_d     = i_sample_stb & ((state_q == S_FLUSH) | (state_q == S_RUN));
`ifdef FIR_TAP_LOADER_FLUSH_EN
        zero_d   = i_sample_stb & (state_q == S_FLUSH);
`else
        zero_d   = 1'b0;
`endif
        loaded_d = (state_q == S_RUN) & ~start_edge_s;
    end

    assign o_tap_ready = (state_q == S_LOAD);
    assign o_busy      = (state_q == S_LOAD) | (state_q == S_FLUSH);

    // Registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            count_q  <= {CNT_W{1'b0}};
            tap_wr_q <= 1'b0;
            tap_q    <= {TAP_W{1'b0}};
            ce_q     <= 1'b0;
            zero_q   <= 1'b0;
            loaded_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            tap_wr_q <= tap_wr_d;
            tap_q    <= tap_d;
            ce_q     <= ce_d;
            zero_q   <= zero_d;
            loaded_q <= loaded_d;
        end
    end

    assign o_tap_count   = count_q;
    assign o_tap_wr      = tap_wr_q;
    assign o_tap         = tap_q;
    assign o_ce          = ce_q;
    assign o_zero_sample = zero_q;
    assign o_loaded      = loaded_q;

endmodule

// File: tb/tb_fir_tap_loader.sv
// Self-checking bench for fir_tap_loader: directed and random steps against a
// transaction-level model of load / flush / run behaviour.
module tb_fir_tap_loader;
    localparam int NTAPS = 16;
    localparam int TAP_W = 16;
    localparam int CNT_W = $clog2(NTAPS + 1);
`ifdef FIR_TAP_LOADER_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif
    localparam int P_IDLE = 0, P_LOAD = 1, P_FLUSH = 2, P_RUN = 3;

    logic             i_clk = 1'b0;
    logic             i_reset, i_start, i_tap_valid, i_sample_stb;
    logic [TAP_W-1:0] i_tap_data;
    logic             o_tap_ready, o_tap_wr, o_ce, o_zero_sample, o_loaded, o_busy;
    logic [TAP_W-1:0] o_tap;
    logic [CNT_W-1:0] o_tap_count;

    fir_tap_loader #(.NTAPS(NTAPS), .TAP_W(TAP_W)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
        .i_tap_valid(i_tap_valid), .o_tap_ready(o_tap_ready), .i_tap_data(i_tap_data),
        .i_sample_stb(i_sample_stb), .o_tap_wr(o_tap_wr), .o_tap(o_tap), .o_ce(o_ce),
        .o_zero_sample(o_zero_sample), .o_loaded(o_loaded), .o_busy(o_busy),
        .o_tap_count(o_tap_count)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int failures = 0;
    int wr_seen = 0;
    int hs_made = 0;

    // Reference model: which phase of a load the block is in, and how far along.
    int m_phase = P_IDLE;
    int m_taps = 0;
    int m_strobes = 0;
    bit m_prev_start = 1'b1;
    logic [TAP_W-1:0] tap_q_exp[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rst, input bit st, input bit v,
                        input logic [TAP_W-1:0] d, input bit stb);
        bit e_wr, e_ce, e_zero, e_loaded, edge_s, hs;
        i_reset = rst; i_start = st; i_tap_valid = v; i_tap_data = d; i_sample_stb = stb;
        if (rst) begin
            e_wr = 0; e_ce = 0; e_zero = 0; e_loaded = 0;
            m_phase = P_IDLE; m_taps = 0; m_strobes = 0; m_prev_start = 1'b1;
            tap_q_exp.delete();
        end else begin
            edge_s   = m_prev_start && !st;
            hs       = v && (m_phase == P_LOAD);
            e_wr     = hs;
            e_ce     = stb && (m_phase == P_FLUSH || m_phase == P_RUN);
            e_zero   = stb && (m_phase == P_FLUSH);
            e_loaded = (m_phase == P_RUN) && !edge_s;
            if (hs) begin
                tap_q_exp.push_back(d);
                hs_made++;
            end
            if (m_phase == P_LOAD) begin
                if (hs) begin
                    m_taps++;
                    if (m_taps == NTAPS) begin
                        m_phase = FLUSH_EN ? P_FLUSH : P_RUN;
                        m_strobes = 0;
                    end
                end
            end else if (edge_s) begin
                m_phase = P_LOAD;
                m_taps = 0;
            end else if (m_phase == P_FLUSH && stb) begin
                m_strobes++;
                if (m_strobes == NTAPS) m_phase = P_RUN;
            end
            m_prev_start = st;
        end
        @(posedge i_clk);
        #1;
        chk("tap_wr", o_tap_wr, e_wr);
        chk("ce", o_ce, e_ce);
        chk("zero_sample", o_zero_sample, e_zero);
        chk("loaded", o_loaded, e_loaded);
        chk("tap_count", o_tap_count, m_taps);
        chk("tap_ready", o_tap_ready, m_phase == P_LOAD);
        chk("busy", o_busy, m_phase == P_LOAD || m_phase == P_FLUSH);
        if (rst) chk("reset_tap", o_tap, 0);
        if (o_tap_wr === 1'b1) begin
            wr_seen++;
            if (tap_q_exp.size() > 0) chk("tap_order", o_tap, tap_q_exp.pop_front());
        end
    endtask

    task automatic rand_steps(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, ($urandom_range(0, 24) != 0), $urandom_range(0, 1),
                 TAP_W'($urandom), ($urandom_range(0, 2) == 0));
    endtask

    initial begin
        i_reset = 1'b1; i_start = 1'b1; i_tap_valid = 1'b0; i_tap_data = '0; i_sample_stb = 1'b0;
        // Held reset with strobes toggling.
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, $urandom_range(0, 1), TAP_W'($urandom), i[0]);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 16'hAAAA, 1'b1);
        // Directed full-rate load 0x0001..0x0010.
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        for (int k = 1; k <= NTAPS; k++) step(1'b0, 1'b1, 1'b1, TAP_W'(k), 1'b0);
        chk("count_full", o_tap_count, NTAPS);
        step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
        if (!FLUSH_EN) chk("loaded_2cyc", o_loaded, 1);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b0, 16'h0, i[0]);
        chk("loaded_run", o_loaded, 1);
        // Start edge in RUN, then a gappy load with stray start edges and strobes.
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("restart_ready", o_tap_ready, 1);
        chk("restart_loaded", o_loaded, 0);
        for (int i = 0; i < 30; i++)
            step(1'b0, i[0], $urandom_range(0, 1), TAP_W'($urandom), $urandom_range(0, 1));
        rand_steps(150);
        // Reset after 7 taps, then a fresh load needs all 16 words.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        if (o_tap_ready !== 1'b1) step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
        for (int k = 0; k < 7; k++) step(1'b0, 1'b1, 1'b1, TAP_W'($urandom), 1'b1);
        step(1'b1, 1'b1, 1'b1, 16'h0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 16'h0, 1'b1);
        chk("rst_count", o_tap_count, 0);
        chk("rst_loaded", o_loaded, 0);
        step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        for (int k = 0; k < NTAPS - 1; k++) step(1'b0, 1'b1, 1'b1, TAP_W'($urandom), 1'b1);
        chk("partial_ready", o_tap_ready, 1);
        step(1'b0, 1'b1, 1'b1, TAP_W'($urandom), 1'b1);
        chk("reload_done", o_tap_ready, 0);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b0, 16'h0, 1'b1);
        rand_steps(500);
        chk("wr_vs_hs", wr_seen, hs_made);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
